// File: rtl/demux4_stream_if.sv
// ============================================================================
// Module   : demux4_stream_if
// Purpose  : Stream bundle for the 1-to-4 demultiplexer. One upstream
//            valid/ready input and four downstream valid/ready channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux4_stream_if #(
   parameter int k = 16
);
   logic [k-1:0] in_data;
   logic [1:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   logic         auto_mode;
   logic [k-1:0] out0;
   logic [k-1:0] out1;
   logic [k-1:0] out2;
   logic [k-1:0] out3;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;

   // Producer and consumer side: drives the input word and the consumer readies.
   modport master (
      output in_data, in_sel, in_valid, auto_mode, out_ready,
      input  in_ready, out0, out1, out2, out3, out_valid
   );

   // Demultiplexer side.
   modport slave (
      input  in_data, in_sel, in_valid, auto_mode, out_ready,
      output in_ready, out0, out1, out2, out3, out_valid
   );
endinterface

`default_nettype wire

// File: rtl/demux4_stream.sv
// ============================================================================
// Module   : demux4_stream
// Purpose  : Registered 1-to-4 stream demultiplexer. Each output channel has
//            a one-entry holding register. The destination is either an
//            explicit select or an internal round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4_stream #(
   parameter int k = 16
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   demux4_stream_if.slave   bus,
   output logic [1:0]       rr_ptr,
   output logic [7:0]       xfer_cnt,
   output logic             busy
);

   logic [k-1:0] r_data [4];
   logic [3:0]   r_valid;
   logic [1:0]   r_rr_ptr;
   logic [7:0]   r_xfer_cnt;

   logic [1:0]   w_dst;
   logic         w_ready;
   logic         w_acc;

   // The destination is resolved in the handshake cycle. in_ready depends only
   // on the addressed channel, so one stalled channel does not block the others.
   assign w_dst   = bus.auto_mode ? r_rr_ptr : bus.in_sel;
   assign w_ready = ~r_valid[w_dst] | bus.out_ready[w_dst];
   assign w_acc   = bus.in_valid & w_ready;

   // Channel holding registers. A load takes priority over a drain, so a
   // simultaneous drain and refill keeps valid high with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_data[i] <= '0;
         end
         r_valid <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_acc && (w_dst == 2'(i))) begin
               r_data[i]  <= bus.in_data;
               r_valid[i] <= 1'b1;
            end else if (r_valid[i] && bus.out_ready[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

   // The transfer counter advances on every accept. The round-robin pointer
   // advances only on accepts made in auto mode, so toggling the mode leaves it
   // where it was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr   <= 2'd0;
         r_xfer_cnt <= 8'd0;
      end else if (w_acc) begin
         r_xfer_cnt <= r_xfer_cnt + 8'd1;
         if (bus.auto_mode) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out0      = r_data[0];
   assign bus.out1      = r_data[1];
   assign bus.out2      = r_data[2];
   assign bus.out3      = r_data[3];
   assign bus.out_valid = r_valid;
   assign rr_ptr        = r_rr_ptr;
   assign xfer_cnt      = r_xfer_cnt;
   assign busy          = |r_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux4_stream.sv
// ============================================================================
// Module   : tb_demux4_stream
// Purpose  : Directed self-checking bench for demux4_stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux4_stream;

   logic       clk;
   logic       rst_n;
   logic [1:0] rr_ptr;
   logic [7:0] xfer_cnt;
   logic       busy;

   int checks = 0;
   int errors = 0;

   demux4_stream_if #(.k(16)) bus ();

   demux4_stream #(.k(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .rr_ptr   (rr_ptr),
      .xfer_cnt (xfer_cnt),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one word at a negedge; it is taken at the following posedge.
   task automatic present(input logic [15:0] d, input logic [1:0] s);
      bus.in_data  = d;
      bus.in_sel   = s;
      bus.in_valid = 1'b1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      // Fill all four channels, then pulse reset between clock edges.
      bus.auto_mode = 1'b0;
      bus.out_ready = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         present(16'h0F00 + 16'(i), 2'(i));
         @(negedge clk);
      end
      idle();
      checks++;
      if (bus.out_valid !== 4'b1111) begin
         errors++;
         $display("FAIL pre_reset_full out_valid=%b want 1111", bus.out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_valid out_valid=%b busy=%b want 0000/0", bus.out_valid, busy);
      end
      checks++;
      if (rr_ptr !== 2'd0 || xfer_cnt !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_cnt rr_ptr=%0d xfer_cnt=%0d want 0/0", rr_ptr, xfer_cnt);
      end
      checks++;
      if (bus.out0 !== 16'h0 || bus.out3 !== 16'h0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_data out0=%h out3=%h in_ready=%b want 0/0/1",
                  bus.out0, bus.out3, bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_explicit_routing();
      bus.auto_mode = 1'b0;
      bus.out_ready = 4'b0000;
      present(16'h00A1, 2'd0);
      @(negedge clk);
      checks++;
      if (bus.out0 !== 16'h00A1 || bus.out_valid !== 4'b0001) begin
         errors++;
         $display("FAIL route_ch0 out0=%h valid=%b want 00a1/0001", bus.out0, bus.out_valid);
      end
      present(16'h00B2, 2'd1);
      @(negedge clk);
      checks++;
      if (bus.out1 !== 16'h00B2 || bus.out_valid !== 4'b0011) begin
         errors++;
         $display("FAIL route_ch1 out1=%h valid=%b want 00b2/0011", bus.out1, bus.out_valid);
      end
      present(16'h00C3, 2'd2);
      @(negedge clk);
      checks++;
      if (bus.out2 !== 16'h00C3 || bus.out_valid !== 4'b0111) begin
         errors++;
         $display("FAIL route_ch2 out2=%h valid=%b want 00c3/0111", bus.out2, bus.out_valid);
      end
      present(16'h00D4, 2'd3);
      @(negedge clk);
      idle();
      checks++;
      if (bus.out3 !== 16'h00D4 || bus.out_valid !== 4'b1111 || xfer_cnt !== 8'd4) begin
         errors++;
         $display("FAIL route_ch3 out3=%h valid=%b xfer_cnt=%0d want 00d4/1111/4",
                  bus.out3, bus.out_valid, xfer_cnt);
      end
      checks++;
      if (bus.out0 !== 16'h00A1 || bus.out1 !== 16'h00B2 || bus.out2 !== 16'h00C3) begin
         errors++;
         $display("FAIL route_hold out0=%h out1=%h out2=%h want 00a1/00b2/00c3",
                  bus.out0, bus.out1, bus.out2);
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 4'b0000;
      present(16'h1234, 2'd2);
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready cycle %0d in_ready=%b want 0", c, bus.in_ready);
         end
         @(negedge clk);
         checks++;
         if (bus.out2 !== 16'h00C3 || xfer_cnt !== 8'd4) begin
            errors++;
            $display("FAIL stall_hold cycle %0d out2=%h xfer_cnt=%0d want 00c3/4", c, bus.out2, xfer_cnt);
         end
      end
      // Channel 1 drains in the same cycle it is refilled.
      present(16'h5678, 2'd1);
      bus.out_ready = 4'b0010;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL other_ch_ready in_ready=%b want 1", bus.in_ready);
      end
      @(negedge clk);
      idle();
      bus.out_ready = 4'b0000;
      checks++;
      if (bus.out1 !== 16'h5678 || bus.out_valid !== 4'b1111 || bus.out2 !== 16'h00C3 ||
          xfer_cnt !== 8'd5) begin
         errors++;
         $display("FAIL other_ch_load out1=%h valid=%b out2=%h xfer_cnt=%0d want 5678/1111/00c3/5",
                  bus.out1, bus.out_valid, bus.out2, xfer_cnt);
      end
   endtask

   task automatic test_drain_refill();
      bus.out_ready = 4'b0001;
      present(16'h0EEE, 2'd0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL refill_ready in_ready=%b want 1", bus.in_ready);
      end
      @(negedge clk);
      idle();
      bus.out_ready = 4'b0000;
      checks++;
      if (bus.out0 !== 16'h0EEE || bus.out_valid[0] !== 1'b1 || xfer_cnt !== 8'd6) begin
         errors++;
         $display("FAIL refill_load out0=%h valid0=%b xfer_cnt=%0d want 0eee/1/6",
                  bus.out0, bus.out_valid[0], xfer_cnt);
      end
      @(negedge clk);
      checks++;
      if (bus.out0 !== 16'h0EEE || bus.out_valid !== 4'b1111) begin
         errors++;
         $display("FAIL refill_hold out0=%h valid=%b want 0eee/1111", bus.out0, bus.out_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  chan [6];
      logic [15:0] got;
      chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      // Drain everything first.
      bus.out_ready = 4'b1111;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_drain valid=%b busy=%b want 0000/0", bus.out_valid, busy);
      end
      bus.auto_mode = 1'b1;
      for (int w = 0; w < 6; w++) begin
         present(16'(w + 1), 2'd3);
         #1;
         checks++;
         if (rr_ptr !== chan[w] || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rr_ptr_word%0d rr_ptr=%0d in_ready=%b want %0d/1", w + 1, rr_ptr,
                     bus.in_ready, chan[w]);
         end
         @(negedge clk);
         case (chan[w])
            2'd0:    got = bus.out0;
            2'd1:    got = bus.out1;
            2'd2:    got = bus.out2;
            default: got = bus.out3;
         endcase
         checks++;
         if (got !== 16'(w + 1) || bus.out_valid !== (4'b0001 << chan[w])) begin
            errors++;
            $display("FAIL rr_word%0d data=%h valid=%b want %h on ch%0d", w + 1, got,
                     bus.out_valid, 16'(w + 1), chan[w]);
         end
      end
      checks++;
      if (rr_ptr !== 2'd2 || xfer_cnt !== 8'd12) begin
         errors++;
         $display("FAIL rr_end rr_ptr=%0d xfer_cnt=%0d want 2/12", rr_ptr, xfer_cnt);
      end
      bus.auto_mode = 1'b0;
      present(16'h0777, 2'd3);
      @(negedge clk);
      idle();
      checks++;
      if (bus.out3 !== 16'h0777 || bus.out_valid[3] !== 1'b1 || rr_ptr !== 2'd2 ||
          xfer_cnt !== 8'd13) begin
         errors++;
         $display("FAIL rr_manual out3=%h valid3=%b rr_ptr=%0d xfer_cnt=%0d want 0777/1/2/13",
                  bus.out3, bus.out_valid[3], rr_ptr, xfer_cnt);
      end
   endtask

   task automatic test_counter_wrap();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      bus.out_ready = 4'b1111;
      bus.auto_mode = 1'b1;
      for (int n = 1; n <= 256; n++) begin
         present(16'(n), 2'd0);
         @(negedge clk);
         if (n == 255) begin
            checks++;
            if (xfer_cnt !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255 xfer_cnt=%0d want 255", xfer_cnt);
            end
         end
      end
      idle();
      checks++;
      if (xfer_cnt !== 8'd0 || rr_ptr !== 2'd0) begin
         errors++;
         $display("FAIL wrap_256 xfer_cnt=%0d rr_ptr=%0d want 0/0", xfer_cnt, rr_ptr);
      end
      checks++;
      if (bus.out3 !== 16'd256) begin
         errors++;
         $display("FAIL wrap_last_word out3=%h want 0100", bus.out3);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL wrap_idle busy=%b valid=%b want 0/0000", busy, bus.out_valid);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_data   = '0;
      bus.in_sel    = 2'd0;
      bus.in_valid  = 1'b0;
      bus.auto_mode = 1'b0;
      bus.out_ready = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_explicit_routing();
      test_backpressure();
      test_drain_refill();
      test_round_robin();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
